// File: rtl/uart_rx_framer_pkg.sv
// Shared types and helpers for the UART receive framer.
// Holds the receiver state encoding, oversample default and tick divider math.
package uart_rx_framer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE_DEF = 16;

    // Clocks per oversample tick; clamped so a fast baud never yields a zero divider.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with a single-entry holding register and error pulses.
// The FSM only moves on oversample ticks; delivery/overrun resolve one clock later.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int TW   = $clog2(OVERSAMPLE) + 1;

    logic            tick;
    logic [1:0]      sync;
    logic            rx_s;
    logic            line_q;
    rx_state_e       state, state_nx;
    logic [TW-1:0]   tick_cnt, tick_cnt_nx;
    logic [2:0]      bit_cnt, bit_cnt_nx;
    logic [7:0]      shreg, shreg_nx;
    logic            deliver, ferr_set;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (tick)
    );

    assign rx_s = sync[1];

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        deliver     = 1'b0;
        ferr_set    = 1'b0;
        if (tick) begin
            case (state)
                // line_q is the level seen on the previous tick, so a held-low line never retriggers
                S_IDLE: if (line_q && !rx_s) begin
                    state_nx    = S_START;
                    tick_cnt_nx = '0;
                end
                S_START: if (tick_cnt == TW'(HALF)) begin
                    tick_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    state_nx    = rx_s ? S_IDLE : S_DATA;
                end else begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                end
                S_DATA: if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    tick_cnt_nx = '0;
                    shreg_nx    = {rx_s, shreg[7:1]};
                    bit_cnt_nx  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = S_STOP;
                end else begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                end
                S_STOP: if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    tick_cnt_nx = '0;
                    state_nx    = S_IDLE;
                    deliver     = rx_s;
                    ferr_set    = !rx_s;
                end else begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync      <= 2'b11;
            line_q    <= 1'b1;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], UART_RX};
            if (tick) line_q <= rx_s;
            state     <= state_nx;
            tick_cnt  <= tick_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            frame_err <= ferr_set;
            overrun   <= deliver && rx_valid && !rx_ready;
            // A same-edge handshake frees the slot, so the new byte replaces the old one
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomised and directed bench for uart_rx_framer against an event-level
// model of the holding register (accept order, overrun, frame errors).
module tb_uart_rx_framer;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BITC     = 32;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       UART_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    uart_rx_framer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // model state
    logic [7:0] exp_acc[$];
    logic       m_full = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         ferr_pend = 0, ovr_pend = 0;
    int         c0 = 0;

    // observations
    logic [7:0] acc_log[$];
    int         n_rise = 0, n_ferr = 0, n_ovr = 0, last_rise = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] last_acc();
        return (acc_log.size() > 0) ? acc_log[acc_log.size()-1] : 8'hxx;
    endfunction

    function automatic logic [31:0] in_window();
        return 32'((cyc - c0 >= 300) && (cyc - c0 <= 320));
    endfunction

    always @(negedge sysclk) begin
        if (reset) begin
            prev_valid = 1'b0; prev_ready = 1'b0; prev_ferr = 1'b0; prev_ovr = 1'b0;
        end else begin
            if (frame_err) begin
                n_ferr++;
                check("ferr_expected", 32'(ferr_pend > 0), 1);
                if (ferr_pend > 0) ferr_pend--;
                check("ferr_pulse_width", 32'(prev_ferr), 0);
                check("ferr_window", in_window(), 1);
            end
            if (overrun) begin
                n_ovr++;
                check("ovr_expected", 32'(ovr_pend > 0), 1);
                if (ovr_pend > 0) ovr_pend--;
                check("ovr_pulse_width", 32'(prev_ovr), 0);
                check("ovr_window", in_window(), 1);
            end
            if (rx_valid && !prev_valid) begin
                n_rise++;
                last_rise = cyc;
                check("deliver_window", in_window(), 1);
            end
            if (prev_valid && !prev_ready) begin
                check("valid_hold", 32'(rx_valid), 1);
                check("data_stable", 32'(rx_data), 32'(prev_data));
            end
            if (rx_valid && rx_ready) begin
                acc_log.push_back(rx_data);
                check("accept_expected", 32'(exp_acc.size() > 0), 1);
                if (exp_acc.size() > 0) check("accept_data", 32'(rx_data), 32'(exp_acc.pop_front()));
            end
            prev_valid = rx_valid; prev_ready = rx_ready; prev_data = rx_data;
            prev_ferr = frame_err; prev_ovr = overrun;
        end
    end

    task automatic clk(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        rx_ready = v;
        if (v && m_full) begin
            exp_acc.push_back(m_byte);
            m_full = 1'b0;
        end
    endtask

    // hs_edge: bench pulses rx_ready exactly on this frame's delivery edge
    task automatic model_frame(input logic [7:0] b, input logic ok, input logic hs_edge);
        if (!ok) ferr_pend++;
        else if (hs_edge) begin exp_acc.push_back(m_byte); m_byte = b; m_full = 1'b1; end
        else if (rx_ready) exp_acc.push_back(b);
        else if (m_full) ovr_pend++;
        else begin m_full = 1'b1; m_byte = b; end
    endtask

    task automatic end_checks();
        check("pending_ferr", 32'(ferr_pend), 0);
        check("pending_ovr", 32'(ovr_pend), 0);
        check("valid_vs_model", 32'(rx_valid), 32'(m_full));
        if (m_full) check("held_data", 32'(rx_data), 32'(m_byte));
        check("accept_backlog", 32'(exp_acc.size()), 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic ok, input int rst_bit, input logic hs_edge);
        c0 = cyc;
        UART_RX = 1'b0;
        clk(BITC);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            if (i == rst_bit) begin
                clk(BITC / 2);
                reset = 1'b1;
                #1;
                check("rst_valid", 32'(rx_valid), 0);
                check("rst_data", 32'(rx_data), 0);
                check("rst_ferr", 32'(frame_err), 0);
                check("rst_ovr", 32'(overrun), 0);
                clk(BITC / 2);
            end else begin
                clk(BITC);
            end
        end
        if (rst_bit < 0) model_frame(b, ok, hs_edge);
        UART_RX = ok;
        clk(BITC);
        UART_RX = 1'b1;
        if (rst_bit < 0) end_checks();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, o0, lat;
        logic [7:0] b;
        logic ok;

        clk(5);
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_data", 32'(rx_data), 0);
        check("reset_ferr", 32'(frame_err), 0);
        check("reset_ovr", 32'(overrun), 0);
        reset = 1'b0;
        clk(40);

        // two back-to-back bytes, consumer always ready
        set_ready(1'b1);
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h55, 1'b1, -1, 1'b0);
        send_frame(8'hA6, 1'b1, -1, 1'b0);
        clk(4);
        check("t1_rises", 32'(n_rise - r0), 2);
        check("t1_byte0", 32'(acc_log[acc_log.size()-2]), 32'h55);
        check("t1_byte1", 32'(last_acc()), 32'hA6);
        check("t1_no_err", 32'(n_ferr - f0 + n_ovr - o0), 0);

        // short low glitch must be rejected, then a frame still works
        r0 = n_rise; f0 = n_ferr;
        UART_RX = 1'b0; clk(10); UART_RX = 1'b1; clk(60);
        check("glitch_no_valid", 32'(n_rise - r0), 0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 0);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        clk(4);
        check("glitch_then_frame", 32'(last_acc()), 32'h5A);

        // bad stop bit, then recovery
        r0 = n_rise; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        check("ferr_count", 32'(n_ferr - f0), 1);
        check("ferr_no_valid", 32'(n_rise - r0), 0);
        clk(40);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        clk(4);
        check("after_ferr_byte", 32'(last_acc()), 32'h81);

        // overrun with consumer stalled
        set_ready(1'b0);
        o0 = n_ovr;
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_count", 32'(n_ovr - o0), 1);
        set_ready(1'b1);
        clk(2);
        check("ovr_drain_valid", 32'(rx_valid), 0);
        check("ovr_drain_byte", 32'(last_acc()), 32'h11);

        // handshake coinciding with delivery of a second byte
        set_ready(1'b0);
        clk(20);
        o0 = n_ovr;
        send_frame(8'h33, 1'b1, -1, 1'b0);
        lat = last_rise - c0;
        r0 = n_rise;
        fork
            send_frame(8'hC4, 1'b1, -1, 1'b1);
            begin
                clk(lat - 1);
                rx_ready = 1'b1;
                clk(1);
                rx_ready = 1'b0;
            end
        join
        check("hs_new_byte", 32'(rx_data), 32'hC4);
        check("hs_valid_cont", 32'(n_rise - r0), 0);
        check("hs_no_ovr", 32'(n_ovr - o0), 0);
        check("hs_old_byte", 32'(last_acc()), 32'h33);
        set_ready(1'b1);
        clk(4);

        // reset mid-frame aborts, next frame intact
        send_frame(8'h7E, 1'b1, 4, 1'b0);
        m_full = 1'b0; exp_acc.delete(); ferr_pend = 0; ovr_pend = 0;
        clk(10);
        reset = 1'b0;
        clk(40);
        send_frame(8'h7E, 1'b1, -1, 1'b0);
        clk(4);
        check("post_reset_byte", 32'(last_acc()), 32'h7E);

        // randomised traffic
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) set_ready(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                UART_RX = 1'b0; clk($urandom_range(1, 10)); UART_RX = 1'b1; clk(50);
            end
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok, -1, 1'b0);
            clk(ok ? $urandom_range(0, 20) : 40 + $urandom_range(0, 20));
        end
        set_ready(1'b1);
        clk(10);
        end_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
